// File: rtl/order_dispatch.sv
// order_dispatch: pops one order from the order cache, dispatches it to one of four engines and
// returns an id/status completion record. Define ORDER_WATCHDOG_EN to build the RUN-state watchdog.
module order_dispatch #(
  parameter int WDT_W = 24
) (
  input  logic        system_clk,
  input  logic        rst_n,
  input  logic        run_en,
  output logic        pop_order_en,
  input  logic        order_valid,
  input  logic        order_valid_r,
  input  logic [2:0]  order,
  input  logic [31:0] id,
  output logic [3:0]  engine_start,
  input  logic [3:0]  engine_done,
  output logic [3:0]  engine_abort,
  output logic        busy,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] done_id,
  output logic [1:0]  done_status,
  output logic [31:0] order_count
);

  typedef enum logic [2:0] {IDLE, WAIT_R, LATCH, ISSUE, RUN, REPORT} state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ILL = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  status_d;
  logic [1:0]  sel_q;
  logic        eng_q;
  logic        ill_q;
  logic [31:0] id_q;
  logic [31:0] done_id_q;
  logic [1:0]  done_status_q;
  logic [31:0] order_count_q;
  logic        done_hit;
  logic        wdt_exp;
  logic [3:0]  sel_onehot;

  assign done_hit   = engine_done[sel_q];
  assign sel_onehot = 4'b0001 << sel_q;

`ifdef ORDER_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Held at zero outside RUN, so it starts from zero on every RUN entry.
  always_comb begin
    wdt_d = '0;
    if (state_q == RUN) wdt_d = wdt_q + {{(WDT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) wdt_q <= '0;
    else        wdt_q <= wdt_d;
  end

  assign wdt_exp = (state_q == RUN) && (&wdt_q);
`else
  assign wdt_exp = 1'b0;
`endif

  always_ff @(posedge system_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    status_d = ST_OK;
    unique case (state_q)
      IDLE:   if (order_valid) state_d = WAIT_R;
      WAIT_R: state_d = LATCH;
      LATCH:  state_d = ISSUE;
      ISSUE: begin
        if (!eng_q) begin
          state_d  = REPORT;
          status_d = ill_q ? ST_ILL : ST_OK;
        end else if (done_hit) begin
          state_d = REPORT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (done_hit) begin
          state_d = REPORT;
        end else if (wdt_exp) begin
          state_d  = REPORT;
          status_d = ST_TMO;
        end
      end
      REPORT: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_order_en = 1'b0;
    engine_start = 4'b0000;
    engine_abort = 4'b0000;
    busy         = (state_q != IDLE);
    done_valid   = (state_q == REPORT);
    unique case (state_q)
      IDLE:    pop_order_en = run_en;
      ISSUE:   if (eng_q) engine_start = sel_onehot;
      RUN:     if (wdt_exp && !done_hit) engine_abort = sel_onehot;
      default: ;
    endcase
  end

  // Order fields are only consumed after LATCH, so they need no reset.
  always_ff @(posedge system_clk) begin
    if (state_q == LATCH) begin
      id_q  <= id;
      sel_q <= order[1:0] - 2'd1;
      eng_q <= (order != 3'd0) && (order <= 3'd4);
      ill_q <= (order >= 3'd5);
    end
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      done_id_q     <= '0;
      done_status_q <= ST_OK;
      order_count_q <= '0;
    end else begin
      if (state_q != REPORT && state_d == REPORT) begin
        done_id_q     <= id_q;
        done_status_q <= status_d;
      end
      if (state_q == REPORT && done_ready) order_count_q <= order_count_q + 32'd1;
    end
  end

  // Cache contract check only: the FSM advances from WAIT_R without consulting order_valid_r.
  always_ff @(posedge system_clk) begin
    if (rst_n && state_q == WAIT_R) assert (order_valid_r);
  end

  assign done_id     = done_id_q;
  assign done_status = done_status_q;
  assign order_count = order_count_q;

endmodule

// File: tb/tb_order_dispatch.sv
// Directed bench for order_dispatch with a small order-cache model feeding the pop side.
module tb_order_dispatch;

  logic        system_clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        pop_order_en;
  logic        order_valid;
  logic        order_valid_r = 1'b0;
  logic [2:0]  order = '0;
  logic [31:0] id = '0;
  logic [3:0]  engine_start;
  logic [3:0]  engine_done;
  logic [3:0]  engine_abort;
  logic        busy;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_id;
  logic [1:0]  done_status;
  logic [31:0] order_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 system_clk = ~system_clk;

  order_dispatch #(.WDT_W(4)) dut (
    .system_clk   (system_clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .pop_order_en (pop_order_en),
    .order_valid  (order_valid),
    .order_valid_r(order_valid_r),
    .order        (order),
    .id           (id),
    .engine_start (engine_start),
    .engine_done  (engine_done),
    .engine_abort (engine_abort),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_id      (done_id),
    .done_status  (done_status),
    .order_count  (order_count)
  );

  // Order cache: accepts a pop combinationally, presents the entry one cycle later.
  logic [2:0]  ops [0:15];
  logic [31:0] ids [0:15];
  int head = 0;
  int tail = 0;

  assign order_valid = pop_order_en && (head != tail);

  always @(posedge system_clk) begin
    order_valid_r <= order_valid;
    if (order_valid) begin
      order <= ops[head];
      id    <= ids[head];
      head  <= head + 1;
    end
  end

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] oid);
    ops[tail] = op;
    ids[tail] = oid;
    tail = tail + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_pop"},   32'(pop_order_en), 32'h0);
    chk({tag, "_dv"},    32'(done_valid), 32'h0);
    chk({tag, "_id"},    done_id, 32'h0);
    chk({tag, "_st"},    32'(done_status), 32'h0);
    chk({tag, "_cnt"},   order_count, 32'h0);
    chk({tag, "_start"}, 32'(engine_start), 32'h0);
    chk({tag, "_abort"}, 32'(engine_abort), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    run_en = 1'b0;
    done_ready = 1'b1;
    engine_done = 4'b0000;
    repeat (3) tick();
    chk_idle_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // Single engine-1 order, done returned at T+10
    push(3'd1, 32'h0000_00A5);
    run_en = 1'b1;
    #1;
    chk("t1_pop", 32'(pop_order_en), 32'h1);
    tick();
    chk("t1_waitr_pop", 32'(pop_order_en), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    tick();
    tick();
    chk("t1_start", 32'(engine_start), 32'h1);
    tick();
    chk("t1_start_off", 32'(engine_start), 32'h0);
    chk("t1_abort", 32'(engine_abort), 32'h0);
    repeat (6) tick();
    engine_done = 4'b0001;
    tick();
    engine_done = 4'b0000;
    chk("t1_dv", 32'(done_valid), 32'h1);
    chk("t1_id", done_id, 32'hA5);
    chk("t1_st", 32'(done_status), 32'h0);
    tick();
    chk("t1_dv_off", 32'(done_valid), 32'h0);
    chk("t1_cnt", order_count, 32'd1);
    chk("t1_idle", 32'(busy), 32'h0);

    // Back-to-back opcodes 1..4, each done five cycles after its start
    for (int k = 1; k <= 4; k++) push(3'(k), 32'(k));
    for (int k = 1; k <= 4; k++) begin
      chk("b2b_pop", 32'(pop_order_en), 32'h1);
      repeat (3) tick();
      chk("b2b_start", 32'(engine_start), 32'(1 << (k - 1)));
      repeat (5) tick();
      engine_done = 4'(1 << (k - 1));
      tick();
      engine_done = 4'b0000;
      chk("b2b_dv", 32'(done_valid), 32'h1);
      chk("b2b_id", done_id, 32'(k));
      chk("b2b_st", 32'(done_status), 32'h0);
      tick();
    end
    chk("b2b_cnt", order_count, 32'd5);

    // NOP then illegal opcode
    push(3'd0, 32'd7);
    push(3'd6, 32'd8);
    repeat (3) tick();
    chk("nop_start", 32'(engine_start), 32'h0);
    tick();
    chk("nop_dv", 32'(done_valid), 32'h1);
    chk("nop_id", done_id, 32'd7);
    chk("nop_st", 32'(done_status), 32'h0);
    tick();
    repeat (3) tick();
    chk("ill_start", 32'(engine_start), 32'h0);
    tick();
    chk("ill_dv", 32'(done_valid), 32'h1);
    chk("ill_id", done_id, 32'd8);
    chk("ill_st", 32'(done_status), 32'h1);
    tick();
    chk("ill_cnt", order_count, 32'd7);

    // Done during ISSUE, then 20 cycles of backpressure with another order waiting
    done_ready = 1'b0;
    push(3'd2, 32'h55);
    push(3'd3, 32'h66);
    repeat (3) tick();
    chk("bp_start", 32'(engine_start), 32'h2);
    engine_done = 4'b0010;
    tick();
    engine_done = 4'b0000;
    chk("bp_dv", 32'(done_valid), 32'h1);
    chk("bp_id", done_id, 32'h55);
    chk("bp_st", 32'(done_status), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold_dv", 32'(done_valid), 32'h1);
      chk("bp_hold_id", done_id, 32'h55);
      chk("bp_hold_pop", 32'(pop_order_en), 32'h0);
    end
    run_en = 1'b0;
    done_ready = 1'b1;
    tick();
    chk("bp_cnt", order_count, 32'd8);
    for (int i = 0; i < 3; i++) begin
      chk("runen_pop", 32'(pop_order_en), 32'h0);
      chk("runen_busy", 32'(busy), 32'h0);
      tick();
    end

    // Reset while engine 2 runs; its late done must be ignored
    run_en = 1'b1;
    #1;
    repeat (3) tick();
    chk("rr_start", 32'(engine_start), 32'h4);
    tick();
    tick();
    rst_n = 1'b0;
    run_en = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle_zero("rr");
    engine_done = 4'b0100;
    tick();
    engine_done = 4'b0000;
    chk("rr_late_busy", 32'(busy), 32'h0);
    chk("rr_late_dv", 32'(done_valid), 32'h0);
    tick();
    chk("rr_late_dv2", 32'(done_valid), 32'h0);
    chk("rr_late_cnt", order_count, 32'h0);

`ifdef ORDER_WATCHDOG_EN
    // Watchdog expiry 15 cycles after RUN entry, then done racing expiry
    run_en = 1'b1;
    push(3'd4, 32'h99);
    repeat (3) tick();
    chk("wd_start", 32'(engine_start), 32'h8);
    tick();
    repeat (14) tick();
    chk("wd_abort_early", 32'(engine_abort), 32'h0);
    tick();
    chk("wd_abort", 32'(engine_abort), 32'h8);
    tick();
    chk("wd_abort_off", 32'(engine_abort), 32'h0);
    chk("wd_dv", 32'(done_valid), 32'h1);
    chk("wd_id", done_id, 32'h99);
    chk("wd_st", 32'(done_status), 32'h2);
    tick();
    push(3'd4, 32'h9A);
    repeat (3) tick();
    tick();
    repeat (15) tick();
    engine_done = 4'b1000;
    #1;
    chk("wd_race_abort", 32'(engine_abort), 32'h0);
    tick();
    engine_done = 4'b0000;
    chk("wd_race_dv", 32'(done_valid), 32'h1);
    chk("wd_race_id", done_id, 32'h9A);
    chk("wd_race_st", 32'(done_status), 32'h0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/order_dispatch.md
# order_dispatch

Pop-side sequencer for the order cache in the `system_clk` domain. It pulls one order at a time from the cache and waits out the cache's two-cycle read pipeline. It then decodes the opcode, fires a one-cycle start to the selected compute engine, and waits for that engine's done. Finally it returns a completion record (id and status) to the host-side response path with a valid/ready handshake.

## Interface
- `WDT_W`, 24, width of the watchdog counter. Timeout occurs at 2^WDT_W−1 cycles in RUN. Only used with `ORDER_WATCHDOG_EN`.
- `system_clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `run_en` in 1: permits popping new orders.
- `pop_order_en` out 1: read request to the cache.
- `order_valid` in 1: cache pop accepted this cycle (combinational from the cache).
- `order_valid_r` in 1: `order_valid` delayed one cycle by the cache.
- `order` in 3: opcode field. Stable from the cycle after `order_valid_r`.
- `id` in 32: order id field. Same timing as `order`.
- `engine_start` out 4: one-hot start pulse.
- `engine_done` in 4: per-engine done pulse.
- `engine_abort` out 4: one-hot abort pulse (watchdog only).
- `busy` out 1: high in any state other than IDLE.
- `done_valid` out 1: completion record valid.
- `done_ready` in 1: completion record accepted.
- `done_id` out 32: id of the completed order.
- `done_status` out 2: 00 ok, 01 illegal opcode, 10 timeout.
- `order_count` out 32: number of completion records accepted; wraps.

## Operation
- States: IDLE, WAIT_R, LATCH, ISSUE, RUN, REPORT.
- IDLE:
  - `pop_order_en` = `run_en`.
  - If `order_valid`=1, go to WAIT_R.
  - An empty cache gives `order_valid`=0, so the block stays in IDLE with pop still asserted; this is harmless.
- WAIT_R:
  - `pop_order_en`=0.
  - Go to LATCH unconditionally. `order_valid_r` is expected high here; it is not re-checked.
- LATCH:
  - Capture `order` and `id` into internal registers.
  - Decode the opcode:
    - 0 = NOP.
    - 1–4 = engine bit (code−1).
    - 5–7 = illegal.
  - Go to ISSUE.
- ISSUE:
  - Engine opcode: `engine_start[code−1]`=1 for this cycle only, then go to RUN.
  - NOP: no start; go to REPORT with status 00.
  - Illegal: no start; go to REPORT with status 01.
- RUN:
  - Wait for `engine_done[sel]`, then go to REPORT with status 00.
  - Done bits of non-selected engines are ignored.
- REPORT:
  - `done_valid`=1 with `done_id`/`done_status`, all held stable until `done_ready`.
  - On `done_valid & done_ready`: increment `order_count` and go to IDLE.
- Engine done arriving during ISSUE is accepted: go directly to REPORT with status 00.
- `run_en` dropping mid-order does not abort the order. The current order completes; no new pop follows.
- Only one order is ever in flight.

## Timing
- Reset values: state IDLE; all outputs 0, including `order_count` and the captured `done_id`/`done_status`.
- `pop_order_en`, `engine_start`, `done_valid` and `busy` are decoded from registered state. They carry no combinational path from inputs except `pop_order_en` ← `run_en`.
- Pop accepted at cycle T (`order_valid`=1):
  - WAIT_R at T+1.
  - LATCH at T+2.
  - `engine_start` high at T+3.
- Done sampled at cycle D:
  - `done_valid` high at D+1.
  - With `done_ready` already high, IDLE at D+2 and the next pop at D+2.
- Minimum order-to-order spacing: 6 cycles for an engine order whose done returns 1 cycle after start; 5 cycles for NOP.
- `rst_n` low on any edge forces IDLE on that edge.
  - An order popped but not reported is lost.
  - An engine already started is not notified.

## Configuration
- `ORDER_WATCHDOG_EN` defined:
  - A `WDT_W`-bit counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches all-ones without done: `engine_abort[sel]` pulses one cycle, then REPORT with status 10.
  - Done and expiry in the same cycle: done wins, status 00.
- `ORDER_WATCHDOG_EN` undefined:
  - No counter is built and `engine_abort` is tied 0.
  - RUN waits indefinitely; status 10 is never produced.

## Test plan
- Single order: opcode 1, id 0x0000_00A5, pop at T, `done_ready`=1.
  - `engine_start`=0001 at T+3.
  - Done at T+10 → `done_valid` at T+11 with `done_id`=0xA5, status 00.
  - `order_count`=1.
- Back-to-back: four orders, opcodes 1–4, ids 1–4, each engine done 5 cycles after start.
  - Starts are one-hot 0001, 0010, 0100, 1000 in order.
  - Completion records carry ids 1–4 in order; `order_count`=4.
- NOP and illegal: opcode 0, id 7 → status 00, no start. Opcode 6, id 8 → status 01, no start.
- Backpressure and run_en:
  - `done_ready` held low 20 cycles → `done_valid`/`done_id` held stable; no pop during that time.
  - `run_en`=0 with a non-empty cache → `pop_order_en` stays 0 and `busy`=0.
- Reset mid-RUN: `rst_n` low for 1 cycle while engine 2 runs.
  - Next cycle: IDLE, all outputs 0.
  - A later `engine_done` is ignored.
- With `ORDER_WATCHDOG_EN`, `WDT_W`=4, no done returned:
  - `engine_abort` pulses 15 cycles after RUN entry, then status 10.
  - Repeat with done on that same cycle → status 00.
